// File: rtl/pattern_signal_gen.sv
// pattern_signal_gen: runtime-loadable serial pattern generator.
// Emits pat_r[idx] on 'out' while running, stepping idx once per clock.
// Supports repeat and one-shot passes, start/stop control, a completion
// pulse and a step index output.
// Optional feature: define FRAME_SYNC_EN to add a 'frame_sync' output that
// marks step 0 of every pass while running.

module pattern_signal_gen #(
  parameter int                 MAX_LEN         = 16,
  parameter int                 LEN_W           = 5,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(16'h0039),
  parameter int                 DEFAULT_LEN     = 6,
  parameter int                 AUTO_START      = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [MAX_LEN-1:0] pattern_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic               start,
  input  logic               stop,
  input  logic               one_shot,
  output logic               out,
  output logic               busy,
  output logic [LEN_W-1:0]   idx,
  output logic               done
`ifdef FRAME_SYNC_EN
  ,
  output logic               frame_sync
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L     = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] DEFAULT_LEN_L = LEN_W'(DEFAULT_LEN);
  localparam logic [LEN_W-1:0] ONE_L         = LEN_W'(1);

  state_t             state;
  state_t             state_n;
  logic [MAX_LEN-1:0] pat_r;
  logic [MAX_LEN-1:0] pat_n;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   len_n;
  logic [LEN_W-1:0]   idx_n;
  logic               mode_r;
  logic               mode_n;
  logic               done_r;
  logic               done_n;
  logic [LEN_W-1:0]   len_clamped;
  logic [LEN_W-1:0]   last_idx;
  logic [MAX_LEN-1:0] pat_shifted;

  // A zero or oversized requested length falls back to the full pattern width.
  always_comb begin
    len_clamped = len_in;
    if ((len_in == '0) || (len_in > MAX_LEN_L)) begin
      len_clamped = MAX_LEN_L;
    end
  end

  // Index of the final step of the current pass.
  always_comb begin
    last_idx = len_r - ONE_L;
  end

  // Next-state logic: stop beats load/start, which beat the normal advance.
  always_comb begin
    state_n = state;
    pat_n   = pat_r;
    len_n   = len_r;
    idx_n   = idx;
    mode_n  = mode_r;
    done_n  = 1'b0;
    if (stop) begin
      state_n = IDLE;
      idx_n   = '0;
      if (load) begin
        pat_n = pattern_in;
        len_n = len_clamped;
      end
    end else if (load || start) begin
      if (load) begin
        pat_n = pattern_in;
        len_n = len_clamped;
      end
      idx_n = '0;
      if (start) begin
        state_n = RUN;
        mode_n  = one_shot;
      end
    end else if (state == RUN) begin
      if (idx != last_idx) begin
        idx_n = idx + ONE_L;
      end else if (!mode_r) begin
        idx_n = '0;
      end else begin
        state_n = IDLE;
        idx_n   = '0;
        done_n  = 1'b1;
      end
    end
  end

  // State and datapath registers with synchronous reset to the defaults.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= (AUTO_START != 0) ? RUN : IDLE;
      pat_r  <= DEFAULT_PATTERN;
      len_r  <= DEFAULT_LEN_L;
      idx    <= '0;
      mode_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      pat_r  <= pat_n;
      len_r  <= len_n;
      idx    <= idx_n;
      mode_r <= mode_n;
      done_r <= done_n;
    end
  end

  // Output bit selection by shifting, so any index width is accepted.
  always_comb begin
    pat_shifted = pat_r >> idx;
    busy        = (state == RUN);
    out         = busy & pat_shifted[0];
    done        = done_r;
  end

`ifdef FRAME_SYNC_EN
  // Marks the first step of each pass while running.
  always_comb begin
    frame_sync = busy & (idx == '0);
  end
`endif

endmodule

// File: tb/tb_pattern_signal_gen.sv
// tb_pattern_signal_gen: directed and randomized checks of pattern_signal_gen
// against a behavioural model that tracks cycles elapsed since the start of
// the current pass. Define FRAME_SYNC_EN to also check frame_sync.

module tb_pattern_signal_gen;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               load;
  logic [MAX_LEN-1:0] pattern_in;
  logic [LEN_W-1:0]   len_in;
  logic               start;
  logic               stop;
  logic               one_shot;
  logic               out;
  logic               busy;
  logic [LEN_W-1:0]   idx;
  logic               done;
`ifdef FRAME_SYNC_EN
  logic               frame_sync;
`endif

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Model: pattern, length, whether a pass is active, pass mode, and the
  // number of cycles elapsed since the pass (re)started at step 0.
  logic [MAX_LEN-1:0] mPat;
  int                 mLen;
  bit                 mActive;
  bit                 mOneShot;
  int                 mT;

  pattern_signal_gen dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .pattern_in (pattern_in),
    .len_in     (len_in),
    .start      (start),
    .stop       (stop),
    .one_shot   (one_shot),
    .out        (out),
    .busy       (busy),
    .idx        (idx),
    .done       (done)
`ifdef FRAME_SYNC_EN
    ,
    .frame_sync (frame_sync)
`endif
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  function automatic int clampLen(input int l);
    return ((l == 0) || (l > MAX_LEN)) ? MAX_LEN : l;
  endfunction

  function automatic bit expBusy();
    return mActive && (!mOneShot || (mT < mLen));
  endfunction

  function automatic int expIdx();
    return expBusy() ? (mT % mLen) : 0;
  endfunction

  function automatic bit expOut();
    return expBusy() && mPat[expIdx()];
  endfunction

  function automatic bit expDone();
    return mActive && mOneShot && (mT == mLen);
  endfunction

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkOne("out",  32'(out),  32'(expOut()));
    checkOne("busy", 32'(busy), 32'(expBusy()));
    checkOne("idx",  32'(idx),  32'(expIdx()));
    checkOne("done", 32'(done), 32'(expDone()));
`ifdef FRAME_SYNC_EN
    checkOne("frame_sync", 32'(frame_sync), 32'(expBusy() && (expIdx() == 0)));
`endif
  endtask

  task automatic applyStimulus(input logic r, input logic ld, input logic [MAX_LEN-1:0] p,
                               input logic [LEN_W-1:0] l, input logic st, input logic sp,
                               input logic os);
    rst        = r;
    load       = ld;
    pattern_in = p;
    len_in     = l;
    start      = st;
    stop       = sp;
    one_shot   = os;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelStep();
    bit wasBusy;
    wasBusy = expBusy();
    if (rst) begin
      mPat     = 16'h0039;
      mLen     = 6;
      mActive  = 1'b1;
      mOneShot = 1'b0;
      mT       = 0;
    end else if (stop) begin
      if (load) begin
        mPat = pattern_in;
        mLen = clampLen(int'(len_in));
      end
      mActive = 1'b0;
      mT      = 0;
    end else if (load || start) begin
      if (load) begin
        mPat = pattern_in;
        mLen = clampLen(int'(len_in));
      end
      if (start) begin
        mActive  = 1'b1;
        mOneShot = one_shot;
      end else begin
        mActive = wasBusy;
      end
      mT = 0;
    end else if (mActive) begin
      mT++;
      if (mOneShot && (mT > mLen)) begin
        mActive = 1'b0;
        mT      = 0;
      end
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelStep();
    cycle++;
    #1;
    checkOutput();
  endtask

  initial begin
    mPat     = '0;
    mLen     = 1;
    mActive  = 1'b0;
    mOneShot = 1'b0;
    mT       = 0;

    // Reset, then free-run the default pattern in repeat mode.
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    checkOne("reset_out",  32'(out),  32'd1);
    checkOne("reset_idx",  32'(idx),  32'd0);
    checkOne("reset_busy", 32'(busy), 32'd1);
    idleInputs();
    for (int k = 0; k < 14; k++) stepCycle();

    // Load a 3-step pattern, then a one-shot pass: 1,0,1 then done.
    applyStimulus(1'b0, 1'b1, 16'h0005, 5'd3, 1'b0, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    stepCycle();
    checkOne("oneshot_step0", 32'(out), 32'd1);
    idleInputs();
    stepCycle();
    checkOne("oneshot_step1", 32'(out), 32'd0);
    stepCycle();
    checkOne("oneshot_step2", 32'(out), 32'd1);
    stepCycle();
    checkOne("oneshot_done", 32'(done), 32'd1);
    checkOne("oneshot_busy", 32'(busy), 32'd0);
    stepCycle();
    checkOne("oneshot_done_clr", 32'(done), 32'd0);

    // Repeat mode with the default-length pattern, stop at step 3.
    applyStimulus(1'b0, 1'b1, 16'h0039, 5'd6, 1'b1, 1'b0, 1'b0);
    stepCycle();
    idleInputs();
    for (int k = 0; k < 20 && idx !== 5'd3; k++) stepCycle();
    checkOne("reach_idx3", 32'(idx), 32'd3);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    stepCycle();
    checkOne("stop_busy", 32'(busy), 32'd0);
    checkOne("stop_done", 32'(done), 32'd0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    stepCycle();
    checkOne("restart_idx", 32'(idx), 32'd0);
    idleInputs();
    for (int k = 0; k < 8; k++) stepCycle();

    // Zero length clamps to the full 16-step pattern.
    applyStimulus(1'b0, 1'b1, 16'hFFFE, 5'd0, 1'b1, 1'b0, 1'b0);
    stepCycle();
    checkOne("clamp_step0", 32'(out), 32'd0);
    idleInputs();
    for (int k = 0; k < 33; k++) stepCycle();

    // Stop wins over start in IDLE; load+start while running restarts.
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    stepCycle();
    checkOne("startstop_busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    stepCycle();
    idleInputs();
    stepCycle();
    stepCycle();
    applyStimulus(1'b0, 1'b1, 16'h000A, 5'd4, 1'b1, 1'b0, 1'b0);
    stepCycle();
    checkOne("loadstart_out", 32'(out), 32'd0);
    checkOne("loadstart_idx", 32'(idx), 32'd0);
    idleInputs();
    for (int k = 0; k < 6; k++) stepCycle();

    // Reset in the middle of a one-shot pass.
    applyStimulus(1'b0, 1'b1, 16'h00F0, 5'd9, 1'b1, 1'b0, 1'b1);
    stepCycle();
    idleInputs();
    stepCycle();
    stepCycle();
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    checkOne("midreset_idx",  32'(idx),  32'd0);
    checkOne("midreset_done", 32'(done), 32'd0);
    idleInputs();
    for (int k = 0; k < 6; k++) stepCycle();

    // Randomized control traffic against the model.
    for (int k = 0; k < 600; k++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 9) == 0),
                    MAX_LEN'($urandom),
                    LEN_W'($urandom_range(0, 31)),
                    ($urandom_range(0, 11) == 0),
                    ($urandom_range(0, 19) == 0),
                    1'($urandom_range(0, 1)));
      stepCycle();
    end

    idleInputs();
    stepCycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
